// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory op codes, FSM states,
// RAM port widths and small op-decoding helpers.
package lsu_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int RAM_AW = 32;
  localparam int RAM_DW = 8;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_store_op(op) || (op == EXE_LB_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LW_OP) || (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  // Index of the final byte of the access (byte count minus one).
  function automatic logic [1:0] last_byte_idx(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 2'd0;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2'd1;
      default:                          return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result formatter: sign- or zero-extends the little-endian byte buffer
// according to the load op.
module load_ext
  import lsu_pkg::*;
(
  input  logic [7:0]        op,
  input  logic [DATA_W-1:0] buf_word,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = buf_word;
    case (op)
      EXE_LB_OP:  result = {{24{buf_word[7]}}, buf_word[7:0]};
      EXE_LBU_OP: result = {24'd0, buf_word[7:0]};
      EXE_LH_OP:  result = {{16{buf_word[15]}}, buf_word[15:0]};
      EXE_LHU_OP: result = {16'd0, buf_word[15:0]};
      default:    result = buf_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: serialises byte/half/word accesses over a byte-wide
// synchronous RAM, stalling the pipeline until the access completes.
module lsu
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RAM_AW-1:0] mem_addr_i,
  input  logic [7:0]        mem_aluop_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic              hold_i,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_wdata,
  input  logic [RAM_DW-1:0] ram_rdata,
  output logic [REG_AW-1:0] waddr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_req
);

  lsu_state_e        state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [RAM_AW-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [7:0]        op_reg;
  logic [REG_AW-1:0] waddr_reg;
  logic              we_reg;
  logic              latch_en;

  logic [7:0]        ld_buf_reg [4];
  logic [7:0]        st_byte [4];
  logic [DATA_W-1:0] ld_word;
  logic [DATA_W-1:0] ld_result;
  logic              op_is_store;
  logic [1:0]        last_idx;
  logic              cap_en;
  logic [1:0]        cap_idx;

  assign op_is_store = is_store_op(op_reg);
  assign last_idx    = last_byte_idx(op_reg);

  // Read data lags issue by one cycle, so the byte landing now belongs to cnt-1.
  assign cap_idx = cnt_reg - 2'd1;
  assign cap_en  = !op_is_store &&
                   (((state_reg == ST_ACCESS) && (cnt_reg != 2'd0)) || (state_reg == ST_WAIT));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign st_byte[gi]         = data_reg[8*gi +: 8];
      assign ld_word[8*gi +: 8]  = ld_buf_reg[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          ld_buf_reg[gi] <= '0;
        end else if (cap_en && (cap_idx == 2'(gi))) begin
          ld_buf_reg[gi] <= ram_rdata;
        end
      end
    end
  endgenerate

  load_ext u_load_ext (
    .op       (op_reg),
    .buf_word (ld_word),
    .result   (ld_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      op_reg    <= '0;
      waddr_reg <= '0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (latch_en) begin
        addr_reg  <= mem_addr_i;
        data_reg  <= rt_data_i;
        op_reg    <= mem_aluop_i;
        waddr_reg <= waddr_i;
        we_reg    <= we_i;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    waddr_o    = '0;
    we_o       = 1'b0;
    wdata_o    = '0;
    stall_req  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (is_mem_op(mem_aluop_i)) begin
          stall_req  = 1'b1;
          latch_en   = 1'b1;
          cnt_next   = 2'd0;
          state_next = ST_ACCESS;
        end else begin
          waddr_o = waddr_i;
          we_o    = we_i;
          wdata_o = wdata_i;
        end
      end
      ST_ACCESS: begin
        stall_req = 1'b1;
        ram_en    = 1'b1;
        ram_we    = op_is_store;
        ram_addr  = addr_reg + {30'd0, cnt_reg};
        ram_wdata = op_is_store ? st_byte[cnt_reg] : 8'd0;
        cnt_next  = cnt_reg + 2'd1;
        if (cnt_reg == last_idx) begin
          state_next = op_is_store ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_req  = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        waddr_o = waddr_reg;
        if (!op_is_store) begin
          we_o    = we_reg;
          wdata_o = ld_result;
        end
        if (!hold_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Reset forces every output quiet in the same cycle, whatever the state.
    if (rst) begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      waddr_o   = '0;
      we_o      = 1'b0;
      wdata_o   = '0;
      stall_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-wide RAM model plus a transaction-level
// reference memory, directed vectors followed by randomized load/store traffic.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_aluop_i;
  logic [31:0] rt_data_i;
  logic        hold_i;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [4:0]  waddr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        stall_req;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_wdata;
  logic        last_we;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .waddr_i    (waddr_i),
    .we_i       (we_i),
    .wdata_i    (wdata_i),
    .mem_addr_i (mem_addr_i),
    .mem_aluop_i(mem_aluop_i),
    .rt_data_i  (rt_data_i),
    .hold_i     (hold_i),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .waddr_o    (waddr_o),
    .we_o       (we_o),
    .wdata_o    (wdata_o),
    .stall_req  (stall_req)
  );

  // Byte-wide synchronous RAM; bytes never written read back a fixed pattern.
  logic       mem_clr;
  logic [7:0] mem [1024];
  logic       mem_vld [1024];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ {a[9:8], a[5:0]} ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem_vld[i] <= 1'b0;
    end else if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr[9:0]]     <= ram_wdata;
        mem_vld[ram_addr[9:0]] <= 1'b1;
      end else begin
        ram_rdata <= mem_vld[ram_addr[9:0]] ? mem[ram_addr[9:0]] : init_byte(ram_addr);
      end
    end
  end

  function automatic logic [7:0] ram_peek(input logic [31:0] a);
    return mem_vld[a[9:0]] ? mem[a[9:0]] : init_byte(a);
  endfunction

  // Reference memory updated per transaction, independent of the RAM bus.
  logic [7:0] ref_mem [1024];
  logic       ref_vld [1024];

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_vld[a[9:0]] ? ref_mem[a[9:0]] : init_byte(a);
  endfunction

  function automatic int op_len(input logic [7:0] op);
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 1;
  endfunction

  function automatic logic op_st(input logic [7:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr);
    longint v = 0;
    int     n = op_len(op);
    for (int k = 0; k < n; k++) v += longint'(ref_byte(addr + 32'(k))) << (8 * k);
    if ((op == EXE_LB_OP || op == EXE_LH_OP) && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] a;
    for (int k = 0; k < op_len(op); k++) begin
      a = addr + 32'(k);
      ref_mem[a[9:0]] = data[8*k +: 8];
      ref_vld[a[9:0]] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Non-memory op: everything passes straight through in the same cycle.
  task automatic alu_op(input logic [7:0] op, input logic [31:0] res, input logic [4:0] wa, input logic we);
    mem_aluop_i = op; wdata_i = res; waddr_i = wa; we_i = we;
    mem_addr_i = $urandom; rt_data_i = $urandom; hold_i = 1'b0;
    #2;
    chk ("alu_wdata", wdata_o, res);
    chk ("alu_waddr", 32'(waddr_o), 32'(wa));
    chk1("alu_we", we_o, we);
    chk1("alu_stall", stall_req, 1'b0);
    chk1("alu_ram_en", ram_en, 1'b0);
    $display("[TB] alu op=%h res=%h we=%b", op, res, we);
    @(posedge clk); #1;
  endtask

  // Memory op: presents the op in IDLE, scrambles inputs while busy, checks
  // the stall length, the DONE outputs, hold behaviour and written bytes.
  task automatic mem_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wa, input logic we, input int hold);
    int          n = op_len(op);
    logic        st = op_st(op);
    int          stalls;
    logic [31:0] exp_w;
    exp_w = st ? 32'd0 : ref_load(op, addr);
    mem_aluop_i = op; mem_addr_i = addr; rt_data_i = data; waddr_i = wa; we_i = we;
    wdata_i = $urandom; hold_i = 1'b0;
    #2;
    chk1("idle_stall", stall_req, 1'b1);
    stalls = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      mem_aluop_i = 8'($urandom); mem_addr_i = $urandom; rt_data_i = $urandom;
      waddr_i = 5'($urandom); we_i = 1'($urandom); wdata_i = $urandom;
      #2;
      if (!stall_req) break;
      stalls++;
    end
    chk("stall_cycles", 32'(stalls), st ? 32'(n + 1) : 32'(n + 2));
    hold_i = (hold > 0);
    last_wdata = wdata_o;
    last_we    = we_o;
    chk ("done_wdata", wdata_o, exp_w);
    chk1("done_we", we_o, st ? 1'b0 : we);
    chk1("done_ram_en", ram_en, 1'b0);
    if (!st) chk("done_waddr", 32'(waddr_o), 32'(wa));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      mem_aluop_i = EXE_SB_OP; mem_addr_i = $urandom;
      hold_i = (h + 1 < hold);
      #2;
      chk1("hold_stall", stall_req, 1'b0);
      chk1("hold_ram_en", ram_en, 1'b0);
      chk ("hold_wdata", wdata_o, exp_w);
      chk1("hold_we", we_o, st ? 1'b0 : we);
    end
    @(posedge clk); #1;
    hold_i = 1'b0;
    if (st) begin
      ref_store(op, addr, data);
      for (int k = 0; k < n; k++)
        chk("store_byte", 32'(ram_peek(addr + 32'(k))), 32'(ref_byte(addr + 32'(k))));
    end
    $display("[TB] mem op=%h addr=%h data=%h stalls=%0d wdata_o=%h hold=%0d",
             op, addr, data, stalls, last_wdata, hold);
  endtask

  logic [7:0] op_tab [8];

  initial begin
    op_tab[0] = EXE_LB_OP;  op_tab[1] = EXE_LH_OP;  op_tab[2] = EXE_LW_OP;  op_tab[3] = EXE_LBU_OP;
    op_tab[4] = EXE_LHU_OP; op_tab[5] = EXE_SB_OP;  op_tab[6] = EXE_SH_OP;  op_tab[7] = EXE_SW_OP;
    for (int i = 0; i < 1024; i++) ref_vld[i] = 1'b0;

    rst = 1'b1; mem_clr = 1'b1; hold_i = 1'b0;
    mem_aluop_i = EXE_LW_OP; mem_addr_i = 32'h100; rt_data_i = 32'hFFFF_FFFF;
    waddr_i = 5'h1F; we_i = 1'b1; wdata_i = 32'h1234;
    @(posedge clk); #2;
    chk1("rst_ram_en", ram_en, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk1("rst_stall", stall_req, 1'b0);
    chk1("rst_we_o", we_o, 1'b0);
    chk ("rst_waddr_o", 32'(waddr_o), 32'd0);
    chk ("rst_wdata_o", wdata_o, 32'd0);
    chk ("rst_ram_addr", ram_addr, 32'd0);
    chk ("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    $display("[TB] reset checked");
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;

    alu_op(8'h20, 32'h5, 5'd3, 1'b1);

    // Build the directed memory image through the DUT itself.
    mem_op(EXE_SW_OP, 32'h100, 32'h4433_2211, 5'd0, 1'b0, 0);
    mem_op(EXE_SB_OP, 32'h7,   32'h1234_5680, 5'd0, 1'b0, 0);
    mem_op(EXE_SH_OP, 32'h3,   32'hABCD_F234, 5'd0, 1'b0, 0);

    mem_op(EXE_LW_OP, 32'h100, $urandom, 5'd8, 1'b1, 0);
    chk("lw_0x100", last_wdata, 32'h4433_2211);
    chk1("lw_we", last_we, 1'b1);
    mem_op(EXE_LB_OP, 32'h7, $urandom, 5'd9, 1'b1, 0);
    chk("lb_0x7", last_wdata, 32'hFFFF_FF80);
    mem_op(EXE_LBU_OP, 32'h7, $urandom, 5'd10, 1'b1, 0);
    chk("lbu_0x7", last_wdata, 32'h0000_0080);
    mem_op(EXE_LH_OP, 32'h3, $urandom, 5'd11, 1'b1, 0);
    chk("lh_0x3", last_wdata, 32'hFFFF_F234);

    mem_op(EXE_SW_OP, 32'h200, 32'hDEAD_BEEF, 5'd4, 1'b1, 0);
    chk("sw_b0", 32'(ram_peek(32'h200)), 32'hEF);
    chk("sw_b3", 32'(ram_peek(32'h203)), 32'hDE);
    chk1("sw_done_we", last_we, 1'b0);

    // Reset in the second ACCESS cycle of a store leaves only byte 0 written.
    mem_aluop_i = EXE_SW_OP; mem_addr_i = 32'h300; rt_data_i = 32'hCAFE_F00D;
    waddr_i = 5'd0; we_i = 1'b0;
    #2;
    chk1("rsw_idle_stall", stall_req, 1'b1);
    @(posedge clk); #3;
    chk1("rsw_acc0_en", ram_en, 1'b1);
    chk ("rsw_acc0_addr", ram_addr, 32'h300);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk1("rsw_ram_en", ram_en, 1'b0);
    chk1("rsw_stall", stall_req, 1'b0);
    chk ("rsw_ram_addr", ram_addr, 32'd0);
    chk ("rsw_wdata_o", wdata_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_aluop_i = 8'h20; wdata_i = 32'h77; we_i = 1'b1; waddr_i = 5'd9;
    #2;
    chk1("rsw_after_stall", stall_req, 1'b0);
    chk ("rsw_after_pass", wdata_o, 32'h77);
    ref_mem[10'h300] = 8'h0D; ref_vld[10'h300] = 1'b1;
    chk("rsw_byte0", 32'(ram_peek(32'h300)), 32'h0D);
    chk("rsw_byte1", 32'(ram_peek(32'h301)), 32'(ref_byte(32'h301)));
    $display("[TB] reset during store checked");
    @(posedge clk); #1;

    // Held load result, then a store issued back-to-back.
    mem_op(EXE_LW_OP, 32'h100, $urandom, 5'd12, 1'b1, 2);
    chk("lw_hold", last_wdata, 32'h4433_2211);
    mem_op(EXE_SB_OP, 32'h10, 32'h0000_005A, 5'd0, 1'b0, 0);
    mem_op(EXE_LBU_OP, 32'h10, $urandom, 5'd13, 1'b1, 0);
    chk("sb_then_lbu", last_wdata, 32'h5A);

    // Address wrap across 0xFFFFFFFF.
    mem_op(EXE_SW_OP, 32'hFFFF_FFFE, 32'h8765_4321, 5'd0, 1'b0, 0);
    mem_op(EXE_LW_OP, 32'hFFFF_FFFE, $urandom, 5'd14, 1'b1, 0);
    chk("lw_wrap", last_wdata, 32'h8765_4321);

    for (int t = 0; t < 30; t++) begin
      int r = $urandom_range(0, 8);
      if (r == 8) alu_op(8'h21, $urandom, 5'($urandom), 1'($urandom));
      else mem_op(op_tab[r], $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 waddr_i/we_i/wdata_i  in  5/1/32  writeback target, enable and ALU result from the EX/MEM latch.
REQ-004 mem_addr_i  in  32  effective byte address from EX; meaningful only for load/store ops.
REQ-005 mem_aluop_i  in  8  op code: EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP, any other value is non-memory.
REQ-006 rt_data_i  in  32  store data; bits [7:0] are stored first.
REQ-007 hold_i  in  1  pipeline held by another stage; the MEM latch does not advance this cycle.
REQ-008 ram_en/ram_we/ram_addr/ram_wdata  out  1/1/32/8  byte-wide synchronous RAM port.
REQ-009 ram_rdata  in  8  read byte, valid the cycle after ram_en=1, ram_we=0.
REQ-010 waddr_o/we_o/wdata_o  out  5/1/32  result to MEM/WB latch.
REQ-011 stall_req  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.

Function
REQ-012 Non-memory op in IDLE: waddr_o/we_o/wdata_o equal inputs combinationally, stall_req=0, ram_en=0.
REQ-013 States: IDLE, ACCESS, WAIT, DONE; 2-bit byte counter cnt; byte count n = 1 (B/BU), 2 (H/HU), 4 (W).
REQ-014 IDLE + memory op: stall_req=1 combinationally, latch addr/op/rt_data/waddr, cnt<=0, go ACCESS.
REQ-015 ACCESS: ram_en=1, ram_addr=addr+cnt, ram_we=1 for stores with ram_wdata=rt_data[8*cnt+7:8*cnt]; cnt++ each cycle; after byte n-1 go WAIT (load) or DONE (store).
REQ-016 Load: byte k returned on ram_rdata the cycle after issue is captured into buffer byte k; WAIT captures the last byte, then go DONE.
REQ-017 Little-endian, no alignment requirement; address increments wrap mod 2^32.
REQ-018 Load result: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW whole word.
REQ-019 DONE: stall_req=0, ram_en=0; loads drive wdata_o=extended result, we_o=latched we; stores drive we_o=0, wdata_o=0.
REQ-020 DONE with hold_i=1 stays DONE with stable outputs; hold_i=0 goes IDLE.
REQ-021 Latency: stall_req high for n+1 cycles (store) or n+2 cycles (load); one DONE cycle follows.
REQ-022 Back-to-back memory ops: the second starts from IDLE the cycle after DONE, no bubble beyond REQ-021.
REQ-023 Inputs are ignored outside IDLE; latched copies alone drive ACCESS/WAIT/DONE.

Reset
REQ-024 While rst=1: ram_en, ram_we, stall_req, we_o are 0; waddr_o, wdata_o, ram_addr, ram_wdata are 0.
REQ-025 Rising edge with rst=1: state<=IDLE, cnt<=0, buffers<=0; an in-flight access is abandoned and partial stores are not undone.

Structure
REQ-026 The new op codes, the state encoding and the RAM port widths go in the shared defines.v.
REQ-027 One combinational sub-module, load_ext, maps (op, 32-bit buffer) to the extended result; everything else stays in lsu.

Verification
REQ-028 LW from 0x100, RAM 0x100..0x103 = 11 22 33 44: stall_req high 6 cycles, wdata_o=0x44332211, we_o=1 in DONE.
REQ-029 LB at 0x7 = 0x80 gives 0xFFFFFF80; LBU at the same address gives 0x00000080; LH at 0x3 (misaligned) with bytes 34 F2 gives 0xFFFFF234.
REQ-030 SW 0xDEADBEEF to 0x200: four ACCESS cycles write EF BE AD DE to 0x200..0x203, then DONE with we_o=0.
REQ-031 ADD result 0x5 with we_i=1: passes through in the same cycle, stall_req=0, ram_en never asserted.
REQ-032 rst=1 during the 2nd ACCESS cycle of SW: outputs zero in that cycle, IDLE next cycle, only byte 0 written.
REQ-033 LW followed by SB with hold_i=1 for 2 DONE cycles: result held stable, SB starts only after hold_i falls.
